// File: rtl/cache_pkg.sv
// cache_pkg: shared constants, AXI encodings, refill FSM states and a line word selector
// for the 2-way set-associative instruction cache (cache_top).
package cache_pkg;

    localparam int unsigned SETS       = 64;
    localparam int unsigned WAYS       = 2;
    localparam int unsigned LINE_WORDS = 4;
    localparam logic [3:0]  AXI_ID     = 4'b0;

    // Byte address split: tag [31:10], index [9:4], offset [3:0]
    localparam int unsigned OFF_W     = 4;
    localparam int unsigned IDX_W     = 6;
    localparam int unsigned TAG_W     = 22;
    localparam int unsigned LINE_BITS = LINE_WORDS * 32;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [7:0] AXI_LEN    = 8'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StAr,
        StR,
        StRefill
    } state_e;

    // Word 0 of a line sits in the least significant 32 bits
    function automatic logic [31:0] line_word(input logic [LINE_BITS-1:0] line,
                                              input logic [1:0]           sel);
        return line[32*sel +: 32];
    endfunction

endpackage

// File: rtl/cache_sram.sv
// cache_sram: synchronous-read RAM with one write and one read address and write-first
// bypass (a write to the address being read returns the new data on the next cycle).
// Ports: clock, reset (async, active-high), i_we/i_waddr/i_wdata write side,
// i_raddr read address, o_rdata registered read data.
// CLEAR_ON_RESET zeroes the contents on reset (used for the valid+tag arrays).
module cache_sram #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned DEPTH          = 64,
    parameter bit          CLEAR_ON_RESET = 1'b0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (i_we && (i_waddr == i_raddr)) begin
            r_rdata <= i_wdata;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    generate
        if (CLEAR_ON_RESET) begin : g_clear
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < int'(DEPTH); i++) begin
                        r_mem[i] <= '0;
                    end
                end else if (i_we) begin
                    r_mem[i_waddr] <= i_wdata;
                end
            end
        end else begin : g_plain
            always_ff @(posedge clock) begin
                if (i_we) begin
                    r_mem[i_waddr] <= i_wdata;
                end
            end
        end
    endgenerate

    assign o_rdata = r_rdata;

endmodule

// File: rtl/cache_top.sv
// cache_top: 2-way set-associative read-only instruction cache with an AXI4 refill master.
// Ports: clock/reset (async, active-high); io_i_addr_pipe/io_i_rvalid_pipe IF1 request;
// io_cache_miss_RM/io_rdata_RM RM-stage response; io_ar*/io_r* AXI read channels;
// io_aw*/io_w*/io_b* AXI write channels (tied off).
// Optional feature macro ICACHE_PERF_EN adds io_hit_cnt/io_miss_cnt counters.
module cache_top (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] io_i_addr_pipe,
    input  logic        io_i_rvalid_pipe,
    output logic        io_cache_miss_RM,
    output logic [31:0] io_rdata_RM,
    output logic [31:0] io_araddr,
    output logic        io_arvalid,
    input  logic        io_arready,
    output logic [7:0]  io_arlen,
    output logic [2:0]  io_arsize,
    output logic [1:0]  io_arburst,
    output logic [3:0]  io_arid,
    input  logic [31:0] io_rdata,
    input  logic [1:0]  io_rresp,
    input  logic        io_rvalid,
    output logic        io_rready,
    input  logic        io_rlast,
    input  logic [3:0]  io_rid,
    output logic [31:0] io_awaddr,
    output logic        io_awvalid,
    input  logic        io_awready,
    output logic [7:0]  io_awlen,
    output logic [2:0]  io_awsize,
    output logic [1:0]  io_awburst,
    output logic [3:0]  io_awid,
    output logic [31:0] io_wdata,
    output logic [3:0]  io_wstrb,
    output logic        io_wvalid,
    output logic        io_wlast,
    input  logic        io_wready,
    output logic        io_bready,
    input  logic [1:0]  io_bresp,
    input  logic        io_bvalid,
    input  logic [3:0]  io_bid
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] io_hit_cnt,
    output logic [31:0] io_miss_cnt
`endif
);
    import cache_pkg::*;

    logic                         r_valid;
    logic [31:0]                  r_addr;
    state_e                       r_state, w_state_next;
    logic [1:0]                   r_beat;
    logic [LINE_WORDS-1:0][31:0]  r_line;
    logic [SETS-1:0]              r_lru;

    logic [TAG_W-1:0]     w_rm_tag;
    logic [IDX_W-1:0]     w_rm_idx, w_rd_idx;
    logic [1:0]           w_rm_off;
    logic                 w_load, w_tag_match, w_hit, w_miss, w_refill;
    logic                 w_hit_way, w_victim;
    logic [TAG_W:0]       w_tag_rd  [WAYS];
    logic [LINE_BITS-1:0] w_data_rd [WAYS];
    logic [WAYS-1:0]      w_way_hit, w_way_we;

    assign w_rm_tag = r_addr[31:10];
    assign w_rm_idx = r_addr[9:4];
    assign w_rm_off = r_addr[3:2];

    // While the RM request waits on a refill the arrays keep reading its set, so the
    // victim choice in REFILL sees the RM set's valid bits.
    assign w_load   = !(r_valid && w_miss);
    assign w_rd_idx = w_load ? io_i_addr_pipe[9:4] : w_rm_idx;
    assign w_refill = (r_state == StRefill);

    generate
        for (genvar w = 0; w < int'(WAYS); w++) begin : g_way
            assign w_way_hit[w] = w_tag_rd[w][TAG_W] && (w_tag_rd[w][TAG_W-1:0] == w_rm_tag);
            assign w_way_we[w]  = w_refill && (w_victim == 1'(w));

            cache_sram #(
                .WIDTH          (TAG_W + 1),
                .DEPTH          (SETS),
                .CLEAR_ON_RESET (1'b1)
            ) u_tag (
                .clock   (clock),
                .reset   (reset),
                .i_we    (w_way_we[w]),
                .i_waddr (w_rm_idx),
                .i_wdata ({1'b1, w_rm_tag}),
                .i_raddr (w_rd_idx),
                .o_rdata (w_tag_rd[w])
            );

            cache_sram #(
                .WIDTH          (LINE_BITS),
                .DEPTH          (SETS),
                .CLEAR_ON_RESET (1'b0)
            ) u_data (
                .clock   (clock),
                .reset   (reset),
                .i_we    (w_way_we[w]),
                .i_waddr (w_rm_idx),
                .i_wdata (r_line),
                .i_raddr (w_rd_idx),
                .o_rdata (w_data_rd[w])
            );
        end
    endgenerate

    assign w_tag_match = |w_way_hit;
    assign w_hit       = r_valid && w_tag_match && !w_refill;
    assign w_miss      = r_valid && !w_tag_match && !w_refill;
    assign w_hit_way   = w_way_hit[1];
    // Invalid way first (way 0 before way 1), otherwise the LRU way
    assign w_victim    = !w_tag_rd[0][TAG_W] ? 1'b0 :
                         !w_tag_rd[1][TAG_W] ? 1'b1 : r_lru[w_rm_idx];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
        end else if (w_load) begin
            r_valid <= io_i_rvalid_pipe;
            r_addr  <= io_i_addr_pipe;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_beat <= '0;
            r_line <= '0;
        end else if ((r_state == StR) && io_rvalid) begin
            r_line[r_beat] <= io_rdata;
            r_beat         <= io_rlast ? 2'd0 : r_beat + 2'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_lru <= '0;
        end else if (w_hit) begin
            r_lru[w_rm_idx] <= ~w_hit_way;
        end else if (w_refill) begin
            r_lru[w_rm_idx] <= ~w_victim;
        end
    end

    always_comb begin
        w_state_next = r_state;
        io_arvalid   = 1'b0;
        io_araddr    = '0;
        io_rready    = 1'b0;
        io_rdata_RM  = '0;
        unique case (r_state)
            StIdle: begin
                if (w_miss) w_state_next = StAr;
            end
            StAr: begin
                io_arvalid = 1'b1;
                io_araddr  = {r_addr[31:OFF_W], {OFF_W{1'b0}}};
                if (io_arready) w_state_next = StR;
            end
            StR: begin
                io_rready = 1'b1;
                if (io_rvalid && io_rlast) w_state_next = StRefill;
            end
            StRefill: begin
                w_state_next = StIdle;
                io_rdata_RM  = line_word(r_line, w_rm_off);
            end
            default: w_state_next = StIdle;
        endcase
        if (w_hit) begin
            io_rdata_RM = line_word(w_hit_way ? w_data_rd[1] : w_data_rd[0], w_rm_off);
        end
    end

    assign io_cache_miss_RM = w_miss;
    assign io_arlen         = AXI_LEN;
    assign io_arsize        = SIZE_4B;
    assign io_arburst       = BURST_INCR;
    assign io_arid          = AXI_ID;

    assign io_awaddr  = '0;
    assign io_awvalid = 1'b0;
    assign io_awlen   = '0;
    assign io_awsize  = '0;
    assign io_awburst = '0;
    assign io_awid    = '0;
    assign io_wdata   = '0;
    assign io_wstrb   = '0;
    assign io_wvalid  = 1'b0;
    assign io_wlast   = 1'b0;
    assign io_bready  = 1'b0;

`ifdef ICACHE_PERF_EN
    logic [31:0] r_hit_cnt, r_miss_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_hit) r_hit_cnt <= r_hit_cnt + 32'd1;
            if ((r_state == StIdle) && w_miss) r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign io_hit_cnt  = r_hit_cnt;
    assign io_miss_cnt = r_miss_cnt;
`endif

    logic w_unused;
    assign w_unused = ^{io_rresp, io_rid, io_awready, io_wready, io_bresp, io_bvalid, io_bid,
                        r_addr[1:0]};

endmodule

// File: tb/tb_cache_top.sv
// tb_cache_top: directed plus random fetch stream against a set/way/LRU reference model,
// with an AXI read slave whose memory word i holds the value i.
module tb_cache_top;

    logic        clock, reset;
    logic [31:0] io_i_addr_pipe;
    logic        io_i_rvalid_pipe;
    logic        io_cache_miss_RM;
    logic [31:0] io_rdata_RM;
    logic [31:0] io_araddr;
    logic        io_arvalid, io_arready;
    logic [7:0]  io_arlen;
    logic [2:0]  io_arsize;
    logic [1:0]  io_arburst;
    logic [3:0]  io_arid;
    logic [31:0] io_rdata;
    logic [1:0]  io_rresp;
    logic        io_rvalid, io_rready, io_rlast;
    logic [3:0]  io_rid;
    logic [31:0] io_awaddr;
    logic        io_awvalid, io_awready;
    logic [7:0]  io_awlen;
    logic [2:0]  io_awsize;
    logic [1:0]  io_awburst;
    logic [3:0]  io_awid;
    logic [31:0] io_wdata;
    logic [3:0]  io_wstrb;
    logic        io_wvalid, io_wlast, io_wready;
    logic        io_bready;
    logic [1:0]  io_bresp;
    logic        io_bvalid;
    logic [3:0]  io_bid;
`ifdef ICACHE_PERF_EN
    logic [31:0] io_hit_cnt, io_miss_cnt;
`endif

    cache_top dut (
        .clock            (clock),
        .reset            (reset),
        .io_i_addr_pipe   (io_i_addr_pipe),
        .io_i_rvalid_pipe (io_i_rvalid_pipe),
        .io_cache_miss_RM (io_cache_miss_RM),
        .io_rdata_RM      (io_rdata_RM),
        .io_araddr        (io_araddr),
        .io_arvalid       (io_arvalid),
        .io_arready       (io_arready),
        .io_arlen         (io_arlen),
        .io_arsize        (io_arsize),
        .io_arburst       (io_arburst),
        .io_arid          (io_arid),
        .io_rdata         (io_rdata),
        .io_rresp         (io_rresp),
        .io_rvalid        (io_rvalid),
        .io_rready        (io_rready),
        .io_rlast         (io_rlast),
        .io_rid           (io_rid),
        .io_awaddr        (io_awaddr),
        .io_awvalid       (io_awvalid),
        .io_awready       (io_awready),
        .io_awlen         (io_awlen),
        .io_awsize        (io_awsize),
        .io_awburst       (io_awburst),
        .io_awid          (io_awid),
        .io_wdata         (io_wdata),
        .io_wstrb         (io_wstrb),
        .io_wvalid        (io_wvalid),
        .io_wlast         (io_wlast),
        .io_wready        (io_wready),
        .io_bready        (io_bready),
        .io_bresp         (io_bresp),
        .io_bvalid        (io_bvalid),
        .io_bid           (io_bid)
`ifdef ICACHE_PERF_EN
        ,
        .io_hit_cnt       (io_hit_cnt),
        .io_miss_cnt      (io_miss_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;
    int ar_count = 0;
    int r_count = 0;
    logic [31:0] cur_addr = 32'h0;

    // Reference model: per-set valid/tag per way and the way to replace next
    bit          m_v   [64][2];
    logic [21:0] m_t   [64][2];
    bit          m_lru [64];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < 64; s++) begin
            m_v[s][0] = 1'b0;
            m_v[s][1] = 1'b0;
            m_lru[s]  = 1'b0;
        end
    endtask

    task automatic model_access(input logic [31:0] a, output bit miss);
        int          s;
        int          vic;
        logic [21:0] t;
        s    = int'(a[9:4]);
        t    = a[31:10];
        miss = 1'b1;
        for (int w = 0; w < 2; w++) begin
            if (m_v[s][w] && m_t[s][w] == t) begin
                miss     = 1'b0;
                m_lru[s] = (w == 0);
            end
        end
        if (miss) begin
            if (!m_v[s][0])      vic = 0;
            else if (!m_v[s][1]) vic = 1;
            else                 vic = int'(m_lru[s]);
            m_v[s][vic] = 1'b1;
            m_t[s][vic] = t;
            m_lru[s]    = (vic == 0);
        end
    endtask

    // Presents a request, returns the RM-stage miss flag seen in the first response cycle
    task automatic fetch(input logic [31:0] a, output logic first_miss);
        bit exp_miss;
        int n;
        model_access(a, exp_miss);
        cur_addr         = a;
        io_i_addr_pipe   = a;
        io_i_rvalid_pipe = 1'b1;
        @(posedge clock);
        #1;
        first_miss = io_cache_miss_RM;
        chk("miss_first", 32'(first_miss), 32'(exp_miss));
        n = 0;
        while (io_cache_miss_RM && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("miss_cleared", 32'(io_cache_miss_RM), 32'd0);
        chk("rdata_RM", io_rdata_RM, a >> 2);
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        io_i_rvalid_pipe = 1'b0;
        model_clear();
        repeat (2) @(posedge clock);
        #3;
        reset = 1'b0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_miss", 32'(io_cache_miss_RM), 32'd0);
        chk("rst_rdata", io_rdata_RM, 32'd0);
        chk("rst_arvalid", 32'(io_arvalid), 32'd0);
        chk("rst_rready", 32'(io_rready), 32'd0);
        chk("rst_araddr", io_araddr, 32'd0);
    endtask

    // AXI read slave: decides at the falling edge what happens at the next rising edge
    initial begin
        bit          ar_hs, r_hs, burst;
        int          beat;
        logic [31:0] base_word;
        logic [31:0] ar_addr_q;
        ar_hs = 0; r_hs = 0; burst = 0; beat = 0; base_word = 0; ar_addr_q = 0;
        io_arready = 1'b0; io_rvalid = 1'b0; io_rdata = '0; io_rlast = 1'b0;
        io_rresp = 2'b00; io_rid = 4'h0;
        forever begin
            @(negedge clock);
            if (reset) begin
                ar_hs = 0; r_hs = 0; burst = 0;
                io_arready = 1'b0; io_rvalid = 1'b0; io_rlast = 1'b0;
            end else begin
                if (ar_hs) begin
                    burst     = 1;
                    beat      = 0;
                    base_word = ar_addr_q >> 2;
                    ar_count++;
                end
                if (r_hs) begin
                    beat++;
                    r_count++;
                    if (beat == 4) burst = 0;
                end
                if (io_arvalid) begin
                    chk("araddr", io_araddr, {cur_addr[31:4], 4'h0});
                    chk("arlen", 32'(io_arlen), 32'd3);
                    chk("arsize_burst_id", {20'h0, io_arsize, io_arburst, io_arid, 3'b0},
                        {20'h0, 3'b010, 2'b01, 4'h0, 3'b0});
                end
                io_arready = !burst && ($urandom_range(0, 1) == 1);
                if (burst) begin
                    io_rvalid = ($urandom_range(0, 3) != 0);
                    io_rdata  = base_word + 32'(beat);
                    io_rlast  = (beat == 3);
                    io_rresp  = 2'($urandom_range(0, 3));
                    io_rid    = 4'($urandom_range(0, 15));
                end else begin
                    io_rvalid = 1'b0;
                    io_rlast  = 1'b0;
                    io_rdata  = $urandom;
                end
                ar_hs     = io_arvalid && io_arready;
                ar_addr_q = io_araddr;
                r_hs      = io_rvalid && io_rready;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        fm;
        int          base, n;
        logic [31:0] a;
        logic [31:0] conf_addr [5];
        logic        conf_miss [5];

        io_i_addr_pipe   = '0;
        io_i_rvalid_pipe = 1'b0;
        io_awready = 1'b0; io_wready = 1'b0;
        io_bresp = 2'b00; io_bvalid = 1'b0; io_bid = 4'h0;
        reset = 1'b1;
        model_clear();
        #1;
        chk_reset_outputs();
        repeat (2) @(posedge clock);
        #3;
        reset = 1'b0;

        // Cold miss then hits within the same line
        fetch(32'h0, fm);  chk("cold_miss", 32'(fm), 32'd1);
        fetch(32'h4, fm);  chk("hit_4", 32'(fm), 32'd0);
        fetch(32'h8, fm);  chk("hit_8", 32'(fm), 32'd0);
        fetch(32'hC, fm);  chk("hit_c", 32'(fm), 32'd0);
        chk("wr_tieoff", {29'h0, io_awvalid, io_wvalid, io_bready}, 32'd0);
        chk("wr_addr_tieoff", io_awaddr | io_wdata | {28'h0, io_wstrb}, 32'd0);

        // Sequential sweep over all 64 sets from cold
        do_reset();
        base = ar_count;
        for (int i = 0; i < 256; i++) fetch(32'(i * 4), fm);
        chk("seq_refills", 32'(ar_count - base), 32'd64);

        // Set-0 conflicts from cold
        do_reset();
        conf_addr[0] = 32'h0;   conf_miss[0] = 1'b1;
        conf_addr[1] = 32'h400; conf_miss[1] = 1'b1;
        conf_addr[2] = 32'h800; conf_miss[2] = 1'b1;
        conf_addr[3] = 32'h0;   conf_miss[3] = 1'b1;
        conf_addr[4] = 32'h800; conf_miss[4] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            fetch(conf_addr[i], fm);
            chk("conflict_miss", 32'(fm), 32'(conf_miss[i]));
        end

        // Idle pipe: no miss, no AR activity
        io_i_rvalid_pipe = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            chk("idle_miss_ar", {30'h0, io_cache_miss_RM, io_arvalid}, 32'd0);
        end

        // Random stream over 8 tags x 4 sets exercises LRU and back-to-back refills
        for (int i = 0; i < 300; i++) begin
            a = (32'($urandom_range(0, 7)) << 10) | (32'($urandom_range(0, 3)) << 4) |
                (32'($urandom_range(0, 3)) << 2);
            fetch(a, fm);
        end

        // Reset in the middle of a burst, after two beats
        cur_addr         = 32'h0012_3450;
        io_i_addr_pipe   = cur_addr;
        io_i_rvalid_pipe = 1'b1;
        base = r_count;
        n    = 0;
        while (r_count < base + 2 && n < 500) begin
            @(negedge clock);
            #2;
            n++;
        end
        chk("two_beats_seen", 32'(r_count - base), 32'd2);
        reset = 1'b1;
        #1;
        chk_reset_outputs();
        io_i_rvalid_pipe = 1'b0;
        model_clear();
        repeat (2) @(posedge clock);
        #3;
        reset = 1'b0;
        fetch(32'h10, fm);
        chk("post_reset_miss", 32'(fm), 32'd1);
        fetch(32'h14, fm);
        chk("post_reset_hit", 32'(fm), 32'd0);

        io_i_rvalid_pipe = 1'b0;
        repeat (2) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
